// File: rtl/axi2s_burst_ctrl.sv
// axi2s_burst_ctrl
//   Burst sequencer for the stream<->AXI bridge. Drains 16-word halves of the
//   stream-to-AXI ping-pong BRAM into a DDR write ring, and fills halves of the
//   AXI-to-stream BRAM from a DDR read ring. Only one burst is outstanding at a
//   time. When both directions request, they alternate.
// Ports
//   AXI_clk, rst            clock, asynchronous active-low reset
//   cfg_en                  run enable; while low and idle, ring pointers clear
//   cfg_wr_base/rd_base     64-B aligned ring base byte addresses
//   cfg_nburst              ring length in bursts (0 behaves as 1)
//   wr_req/wr_half/wr_done  drain request, half select, completion pulse
//   rd_req/rd_half/rd_done  fill request, half select, completion pulse
//   s2a_en/s2a_addr         stream-to-AXI BRAM port B read control
//   a2s_en/a2s_wea/a2s_addr AXI-to-stream BRAM port A write control
//   AXI_aw*/w*/b*/ar*/r*    AXI3 control signals; data paths bypass this block
//   err                     sticky response/last error, cleared while cfg_en=0
module axi2s_burst_ctrl #(
  parameter int          BURST_BEATS = 16,
  parameter logic [11:0] ID          = 12'd0
) (
  input  logic        AXI_clk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic [31:0] cfg_wr_base,
  input  logic [31:0] cfg_rd_base,
  input  logic [15:0] cfg_nburst,
  input  logic        wr_req,
  input  logic        wr_half,
  output logic        wr_done,
  input  logic        rd_req,
  input  logic        rd_half,
  output logic        rd_done,
  output logic        s2a_en,
  output logic [4:0]  s2a_addr,
  output logic        a2s_en,
  output logic        a2s_wea,
  output logic [4:0]  a2s_addr,
  output logic [11:0] AXI_awid,
  output logic [31:0] AXI_awaddr,
  output logic [3:0]  AXI_awlen,
  output logic [2:0]  AXI_awsize,
  output logic [1:0]  AXI_awburst,
  output logic [1:0]  AXI_awlock,
  output logic [3:0]  AXI_awcache,
  output logic [2:0]  AXI_awprot,
  output logic [3:0]  AXI_awqos,
  output logic        AXI_awvalid,
  input  logic        AXI_awready,
  output logic [11:0] AXI_wid,
  output logic [3:0]  AXI_wstrb,
  output logic        AXI_wlast,
  output logic        AXI_wvalid,
  input  logic        AXI_wready,
  input  logic [1:0]  AXI_bresp,
  input  logic        AXI_bvalid,
  output logic        AXI_bready,
  output logic [11:0] AXI_arid,
  output logic [31:0] AXI_araddr,
  output logic [3:0]  AXI_arlen,
  output logic [2:0]  AXI_arsize,
  output logic [1:0]  AXI_arburst,
  output logic [1:0]  AXI_arlock,
  output logic [3:0]  AXI_arcache,
  output logic [2:0]  AXI_arprot,
  output logic [3:0]  AXI_arqos,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  input  logic [1:0]  AXI_rresp,
  input  logic        AXI_rlast,
  input  logic        AXI_rvalid,
  output logic        AXI_rready,
  output logic        err
);

  localparam logic [3:0] LEN    = 4'(BURST_BEATS - 1);
  localparam logic [4:0] NBEATS = 5'(BURST_BEATS);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t      state_reg, state_next;
  logic [15:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic        wr_half_reg, wr_half_next, rd_half_reg, rd_half_next;
  logic        last_wr_reg, last_wr_next;     // 1: write was served last
  logic [4:0]  fetched_reg, fetched_next;     // BRAM words read this burst
  logic [3:0]  wbeat_reg, wbeat_next;         // W beats accepted
  logic [3:0]  rbeat_reg, rbeat_next;         // R beats received
  logic        wvalid_reg, wvalid_next;
  logic        wr_done_reg, wr_done_next, wr_done_d_reg;
  logic        rd_done_reg, rd_done_next, rd_done_d_reg;
  logic        err_reg, err_next, err_set;
  logic        wr_ok, rd_ok, wr_wrap, rd_wrap;

  // A requester may still show its req for the done cycle and the one after;
  // those stale levels must not start another burst.
  assign wr_ok   = wr_req && !wr_done_reg && !wr_done_d_reg;
  assign rd_ok   = rd_req && !rd_done_reg && !rd_done_d_reg;
  assign wr_wrap = (cfg_nburst <= 16'd1) || (wr_ptr_reg == cfg_nburst - 16'd1);
  assign rd_wrap = (cfg_nburst <= 16'd1) || (rd_ptr_reg == cfg_nburst - 16'd1);

  always_comb begin
    state_next   = state_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    wr_half_next = wr_half_reg;
    rd_half_next = rd_half_reg;
    last_wr_next = last_wr_reg;
    fetched_next = fetched_reg;
    wbeat_next   = wbeat_reg;
    rbeat_next   = rbeat_reg;
    wvalid_next  = wvalid_reg;
    wr_done_next = 1'b0;
    rd_done_next = 1'b0;
    err_set      = 1'b0;
    AXI_awvalid  = 1'b0;
    AXI_arvalid  = 1'b0;
    AXI_bready   = 1'b0;
    AXI_rready   = 1'b0;
    s2a_en       = 1'b0;
    a2s_en       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!cfg_en) begin
          wr_ptr_next = 16'd0;
          rd_ptr_next = 16'd0;
        end else if (wr_ok && (!rd_ok || !last_wr_reg)) begin
          wr_half_next = wr_half;
          last_wr_next = 1'b1;
          fetched_next = 5'd0;
          wbeat_next   = 4'd0;
          state_next   = S_AW;
        end else if (rd_ok) begin
          rd_half_next = rd_half;
          last_wr_next = 1'b0;
          rbeat_next   = 4'd0;
          state_next   = S_AR;
        end
      end
      S_AW: begin
        AXI_awvalid = 1'b1;
        if (AXI_awready) state_next = S_W;
      end
      S_W: begin
        // Prefetch the next word whenever the output register is empty or
        // being consumed; doutb holds while enb is low, so a stall is free.
        s2a_en = (fetched_reg < NBEATS) && (!wvalid_reg || AXI_wready);
        if (s2a_en) fetched_next = fetched_reg + 5'd1;
        wvalid_next = s2a_en ? 1'b1 : (AXI_wready ? 1'b0 : wvalid_reg);
        if (wvalid_reg && AXI_wready) begin
          wbeat_next = wbeat_reg + 4'd1;
          if (wbeat_reg == LEN) state_next = S_B;
        end
      end
      S_B: begin
        AXI_bready = 1'b1;
        if (AXI_bvalid) begin
          wr_done_next = 1'b1;
          wr_ptr_next  = wr_wrap ? 16'd0 : wr_ptr_reg + 16'd1;
          err_set      = (AXI_bresp != 2'b00);
          state_next   = S_IDLE;
        end
      end
      S_AR: begin
        AXI_arvalid = 1'b1;
        if (AXI_arready) state_next = S_R;
      end
      S_R: begin
        AXI_rready = 1'b1;
        a2s_en     = AXI_rvalid;
        if (AXI_rvalid) begin
          rbeat_next = rbeat_reg + 4'd1;
          // The burst length is fixed; a misplaced rlast only flags an error.
          err_set = (AXI_rresp != 2'b00) || (AXI_rlast != (rbeat_reg == LEN));
          if (rbeat_reg == LEN) begin
            rd_done_next = 1'b1;
            rd_ptr_next  = rd_wrap ? 16'd0 : rd_ptr_reg + 16'd1;
            state_next   = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    err_next = cfg_en ? (err_reg || err_set) : 1'b0;
  end

  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= 16'd0;
      rd_ptr_reg    <= 16'd0;
      wr_half_reg   <= 1'b0;
      rd_half_reg   <= 1'b0;
      last_wr_reg   <= 1'b0;
      fetched_reg   <= 5'd0;
      wbeat_reg     <= 4'd0;
      rbeat_reg     <= 4'd0;
      wvalid_reg    <= 1'b0;
      wr_done_reg   <= 1'b0;
      wr_done_d_reg <= 1'b0;
      rd_done_reg   <= 1'b0;
      rd_done_d_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_half_reg   <= wr_half_next;
      rd_half_reg   <= rd_half_next;
      last_wr_reg   <= last_wr_next;
      fetched_reg   <= fetched_next;
      wbeat_reg     <= wbeat_next;
      rbeat_reg     <= rbeat_next;
      wvalid_reg    <= wvalid_next;
      wr_done_reg   <= wr_done_next;
      wr_done_d_reg <= wr_done_reg;
      rd_done_reg   <= rd_done_next;
      rd_done_d_reg <= rd_done_reg;
      err_reg       <= err_next;
    end
  end

  // Addresses are only presented while the matching valid is high.
  assign AXI_awaddr  = (state_reg == S_AW) ? cfg_wr_base + {10'd0, wr_ptr_reg, 6'd0} : 32'd0;
  assign AXI_araddr  = (state_reg == S_AR) ? cfg_rd_base + {10'd0, rd_ptr_reg, 6'd0} : 32'd0;
  assign AXI_wvalid  = wvalid_reg;
  assign AXI_wlast   = wvalid_reg && (wbeat_reg == LEN);
  assign s2a_addr    = {wr_half_reg, fetched_reg[3:0]};
  assign a2s_wea     = a2s_en;
  assign a2s_addr    = {rd_half_reg, rbeat_reg};
  assign wr_done     = wr_done_reg;
  assign rd_done     = rd_done_reg;
  assign err         = err_reg;

  assign AXI_awid    = ID;
  assign AXI_awlen   = LEN;
  assign AXI_awsize  = 3'b010;
  assign AXI_awburst = 2'b01;
  assign AXI_awlock  = 2'b00;
  assign AXI_awcache = 4'b0011;
  assign AXI_awprot  = 3'b000;
  assign AXI_awqos   = 4'b0000;
  assign AXI_wid     = ID;
  assign AXI_wstrb   = 4'hF;
  assign AXI_arid    = ID;
  assign AXI_arlen   = LEN;
  assign AXI_arsize  = 3'b010;
  assign AXI_arburst = 2'b01;
  assign AXI_arlock  = 2'b00;
  assign AXI_arcache = 4'b0011;
  assign AXI_arprot  = 3'b000;
  assign AXI_arqos   = 4'b0000;

endmodule
